rr_encoder32_5: RTL and testbench



---
 rtl/rr_encoder32_5_if.sv | 40 ++++
 rtl/rr_encoder32_5.sv | 88 ++++++++
 tb/tb_rr_encoder32_5.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_encoder32_5_if.sv
// ---------------------------------------------------------------------------
// rr_encoder32_5_if
// Bundle of the request/handshake/status signals of the round-robin
// 32-to-5 encoder. Names are from the encoder's point of view.
//   i_req     [31:0] request pulses, bit i marks source i pending
//   i_ready          consumer accepts o_idx when o_valid && i_ready
//   o_valid          o_idx holds a pending source
//   o_idx     [4:0]  encoded source index
//   o_drop           one-cycle pulse: a request hit an already-pending bit
//   o_pending [31:0] sticky pending mask (status)
// Modports:
//   slave  - the encoder itself
//   master - the agent driving requests and consuming indices
// ---------------------------------------------------------------------------
interface rr_encoder32_5_if;
  logic [31:0] i_req;
  logic        i_ready;
  logic        o_valid;
  logic [4:0]  o_idx;
  logic        o_drop;
  logic [31:0] o_pending;

  modport slave (
    input  i_req,
    input  i_ready,
    output o_valid,
    output o_idx,
    output o_drop,
    output o_pending
  );

  modport master (
    output i_req,
    output i_ready,
    input  o_valid,
    input  o_idx,
    input  o_drop,
    input  o_pending
  );
endinterface

// File: rtl/rr_encoder32_5.sv
// ---------------------------------------------------------------------------
// rr_encoder32_5
// Round-robin 32-to-5 request encoder. Request pulses are merged into a
// sticky pending mask; one pending source at a time is offered as a 5-bit
// index over a valid/ready handshake, with priority rotating to the source
// after the last one accepted.
// Ports:
//   i_clock    rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        rr_encoder32_5_if.slave (req, ready, valid, idx, drop, pending)
// ---------------------------------------------------------------------------
module rr_encoder32_5 (
  input  logic              i_clock,
  input  logic              i_reset_n,
  rr_encoder32_5_if.slave   bus
);

  logic [31:0] r_pend;
  logic [4:0]  r_ptr;
  logic        r_valid;
  logic [4:0]  r_idx;
  logic        r_drop;

  logic        w_accept;
  logic [31:0] w_acc_mask;
  logic [31:0] w_cand;
  logic [31:0] w_rot;
  logic [4:0]  w_ptr_next;
  logic [4:0]  w_off;
  logic [4:0]  w_sel;
  logic        w_any;

  assign w_accept   = r_valid & bus.i_ready;
  assign w_acc_mask = w_accept ? (32'd1 << r_idx) : 32'd0;
  // Candidates come from the registered mask only; this cycle's requests
  // are not eligible until they have been captured.
  assign w_cand     = r_pend & ~w_acc_mask;
  assign w_ptr_next = w_accept ? (r_idx + 5'd1) : r_ptr;

  // Rotate the candidates so that bit 0 of w_rot is source w_ptr_next;
  // the 5-bit index sum wraps 31 -> 0 naturally.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rot
      assign w_rot[gi] = w_cand[5'(gi) + w_ptr_next];
    end
  endgenerate

  assign w_any = |w_rot;

  // Lowest set bit of the rotated vector = first candidate at or after
  // the pointer.
  always_comb begin
    w_off = 5'd0;
    for (int k = 31; k >= 0; k--) begin
      if (w_rot[k]) w_off = 5'(k);
    end
  end

  assign w_sel = w_ptr_next + w_off;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend  <= 32'd0;
      r_ptr   <= 5'd0;
      r_valid <= 1'b0;
      r_idx   <= 5'd0;
      r_drop  <= 1'b0;
    end else begin
      // A request on the bit being accepted re-queues it without a drop.
      r_pend <= w_cand | bus.i_req;
      r_ptr  <= w_ptr_next;
      r_drop <= |(bus.i_req & w_cand);
      // Output register only reloads when empty or being consumed, so an
      // offered index stays put under backpressure.
      if (!r_valid || w_accept) begin
        r_valid <= w_any;
        r_idx   <= w_any ? w_sel : 5'd0;
      end
    end
  end

  assign bus.o_valid   = r_valid;
  assign bus.o_idx     = r_idx;
  assign bus.o_drop    = r_drop;
  assign bus.o_pending = r_pend;

endmodule

// File: tb/tb_rr_encoder32_5.sv
// ---------------------------------------------------------------------------
// tb_rr_encoder32_5
// Self-checking bench for rr_encoder32_5: a table of directed vectors with
// hand-derived expectations, hand-written reset and full-mask sequences, and
// a randomized phase compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_rr_encoder32_5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_encoder32_5_if bus ();

  rr_encoder32_5 dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    logic [31:0] req;
    logic        rdy;
    logic        exp_valid;
    logic [4:0]  exp_idx;
    logic        exp_drop;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t vq[$];

  // Reference model: pending set, rotation pointer, output slot.
  bit [31:0] m_pend;
  int        m_ptr;
  bit        m_valid;
  int        m_idx;
  bit        m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_valid = 0; m_idx = 0; m_drop = 0;
  endtask

  task automatic model_step(input logic [31:0] req, input logic rdy);
    int acc_i;
    bit found;
    bit [31:0] np;
    acc_i = (m_valid && rdy) ? m_idx : -1;
    m_drop = 0;
    for (int i = 0; i < 32; i++)
      if (req[i] && m_pend[i] && i != acc_i) m_drop = 1;
    if (acc_i >= 0) m_ptr = (acc_i + 1) % 32;
    if (!m_valid || acc_i >= 0) begin
      found = 0;
      m_idx = 0;
      for (int k = 0; k < 32; k++) begin
        int j;
        j = (m_ptr + k) % 32;
        if (!found && m_pend[j] && j != acc_i) begin
          found = 1;
          m_idx = j;
        end
      end
      m_valid = found;
    end
    for (int i = 0; i < 32; i++)
      np[i] = (m_pend[i] && i != acc_i) || req[i];
    m_pend = np;
  endtask

  task automatic step(input logic [31:0] req, input logic rdy);
    @(negedge clk);
    bus.i_req   = req;
    bus.i_ready = rdy;
    @(posedge clk);
    model_step(req, rdy);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.i_req   = '0;
    bus.i_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic add(input bit rst, input logic [31:0] req, input logic rdy,
                     input logic v, input logic [4:0] i, input logic d,
                     input logic [31:0] p);
    vec_t e;
    e.rst = rst; e.req = req; e.rdy = rdy;
    e.exp_valid = v; e.exp_idx = i; e.exp_drop = d; e.exp_pend = p;
    vq.push_back(e);
  endtask

  initial begin
    bus.i_req   = '0;
    bus.i_ready = 1'b0;
    model_reset();

    // Each row: inputs applied for one cycle, outputs expected after that edge.
    // Single request
    add(1, 32'h0000_0001, 1, 0, 0,  0, 32'h0000_0001);
    add(0, 32'h0,         1, 1, 0,  0, 32'h0000_0001);
    add(0, 32'h0,         1, 0, 0,  0, 32'h0);
    // Rotation and wrap (from pointer 0)
    add(1, 32'h8000_0001, 1, 0, 0,  0, 32'h8000_0001);
    add(0, 32'h0,         1, 1, 0,  0, 32'h8000_0001);
    add(0, 32'h0,         1, 1, 31, 0, 32'h8000_0000);
    add(0, 32'h0,         1, 0, 0,  0, 32'h0);
    add(0, 32'h0000_0003, 1, 0, 0,  0, 32'h0000_0003);
    add(0, 32'h0,         1, 1, 0,  0, 32'h0000_0003);
    add(0, 32'h0,         1, 1, 1,  0, 32'h0000_0002);
    add(0, 32'h0,         1, 0, 0,  0, 32'h0);
    // Burst
    add(1, 32'h0000_000F, 1, 0, 0,  0, 32'h0000_000F);
    add(0, 32'h0,         1, 1, 0,  0, 32'h0000_000F);
    add(0, 32'h0,         1, 1, 1,  0, 32'h0000_000E);
    add(0, 32'h0,         1, 1, 2,  0, 32'h0000_000C);
    add(0, 32'h0,         1, 1, 3,  0, 32'h0000_0008);
    add(0, 32'h0,         1, 0, 0,  0, 32'h0);
    // Backpressure (pointer now 4); bit 1 arrives in cycle 4 and must not preempt
    add(0, 32'h0000_0010, 0, 0, 0,  0, 32'h0000_0010);
    add(0, 32'h0,         0, 1, 4,  0, 32'h0000_0010);
    add(0, 32'h0,         0, 1, 4,  0, 32'h0000_0010);
    add(0, 32'h0,         0, 1, 4,  0, 32'h0000_0010);
    add(0, 32'h0000_0002, 0, 1, 4,  0, 32'h0000_0012);
    for (int n = 0; n < 5; n++)
      add(0, 32'h0,       0, 1, 4,  0, 32'h0000_0012);
    add(0, 32'h0,         1, 1, 1,  0, 32'h0000_0002);
    add(0, 32'h0,         1, 0, 0,  0, 32'h0);
    // Drop and re-request
    add(0, 32'h0000_0020, 0, 0, 0,  0, 32'h0000_0020);
    add(0, 32'h0,         0, 1, 5,  0, 32'h0000_0020);
    add(0, 32'h0,         0, 1, 5,  0, 32'h0000_0020);
    add(0, 32'h0000_0020, 0, 1, 5,  1, 32'h0000_0020);
    add(0, 32'h0,         0, 1, 5,  0, 32'h0000_0020);
    add(0, 32'h0000_0020, 1, 0, 0,  0, 32'h0000_0020);
    add(0, 32'h0,         1, 1, 5,  0, 32'h0000_0020);
    add(0, 32'h0,         1, 0, 0,  0, 32'h0);

    apply_reset();
    chk("reset_valid",   32'(bus.o_valid), 32'd0);
    chk("reset_idx",     32'(bus.o_idx),   32'd0);
    chk("reset_drop",    32'(bus.o_drop),  32'd0);
    chk("reset_pending", bus.o_pending,    32'd0);

    foreach (vq[n]) begin
      if (vq[n].rst) apply_reset();
      step(vq[n].req, vq[n].rdy);
      chk($sformatf("vec%0d_valid", n),   32'(bus.o_valid), 32'(vq[n].exp_valid));
      chk($sformatf("vec%0d_idx", n),     32'(bus.o_idx),   32'(vq[n].exp_idx));
      chk($sformatf("vec%0d_drop", n),    32'(bus.o_drop),  32'(vq[n].exp_drop));
      chk($sformatf("vec%0d_pending", n), bus.o_pending,    vq[n].exp_pend);
      $display("vec %0d: req=%08h rdy=%0b -> valid=%0b idx=%0d drop=%0b pending=%08h",
               n, vq[n].req, vq[n].rdy, bus.o_valid, bus.o_idx, bus.o_drop, bus.o_pending);
    end

    // Full mask: 32 back-to-back accepts in rotation order from pointer 0
    apply_reset();
    step(32'hFFFF_FFFF, 1);
    chk("full_pending", bus.o_pending, 32'hFFFF_FFFF);
    for (int k = 0; k < 32; k++) begin
      step(32'h0, 1);
      chk($sformatf("full%0d_valid", k), 32'(bus.o_valid), 32'd1);
      chk($sformatf("full%0d_idx", k),   32'(bus.o_idx),   32'(k));
      $display("full: idx=%0d valid=%0b", bus.o_idx, bus.o_valid);
    end
    step(32'h0, 1);
    chk("full_end_valid",   32'(bus.o_valid), 32'd0);
    chk("full_end_pending", bus.o_pending,    32'd0);

    // Asynchronous reset in the middle of a held handshake
    apply_reset();
    step(32'hFFFF_FFFF, 0);
    step(32'h0, 0);
    chk("pre_rst_valid",   32'(bus.o_valid), 32'd1);
    chk("pre_rst_pending", bus.o_pending,    32'hFFFF_FFFF);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",   32'(bus.o_valid), 32'd0);
    chk("async_rst_idx",     32'(bus.o_idx),   32'd0);
    chk("async_rst_drop",    32'(bus.o_drop),  32'd0);
    chk("async_rst_pending", bus.o_pending,    32'd0);
    bus.i_req   = 32'hFFFF_FFFF;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ignores_req", bus.o_pending, 32'd0);
    @(negedge clk);
    bus.i_req = '0;
    rst_n     = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      step(32'h0, 1);
      chk("post_rst_idle_valid",   32'(bus.o_valid), 32'd0);
      chk("post_rst_idle_pending", bus.o_pending,    32'd0);
    end
    step(32'h0000_0100, 1);
    step(32'h0, 1);
    chk("post_rst_new_valid", 32'(bus.o_valid), 32'd1);
    chk("post_rst_new_idx",   32'(bus.o_idx),   32'd8);
    $display("reset sequence: new request served idx=%0d", bus.o_idx);

    // Randomized traffic against the reference model
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      logic rd;
      r  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      rd = ($urandom_range(0, 9) < 7);
      step(r, rd);
      chk("rnd_valid",   32'(bus.o_valid), 32'(m_valid));
      chk("rnd_idx",     32'(bus.o_idx),   32'(m_idx));
      chk("rnd_drop",    32'(bus.o_drop),  32'(m_drop));
      chk("rnd_pending", bus.o_pending,    m_pend);
      if (bus.o_valid)
        $display("rnd %0d: req=%08h rdy=%0b valid idx=%0d drop=%0b pending=%08h",
                 n, r, rd, bus.o_idx, bus.o_drop, bus.o_pending);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
